// File: rtl/corner_pkg.sv
// Shared record format, field widths and packer state encoding.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package corner_pkg;

    localparam int REC_W   = 24;
    localparam int COORD_W = 10;
    localparam int CNT_W   = 12;
    localparam int DROP_W  = 8;

    localparam logic [3:0] TAG_CORNER = 4'h1;
    localparam logic [3:0] TAG_EOF    = 4'hF;

    typedef enum logic {
        ST_RUN      = 1'b0,
        ST_EOF_PEND = 1'b1
    } state_t;

    function automatic logic [REC_W-1:0] corner_rec(input logic [COORD_W-1:0] y,
                                                    input logic [COORD_W-1:0] x);
        return {TAG_CORNER, y, x};
    endfunction

    function automatic logic [REC_W-1:0] eof_rec(input logic [DROP_W-1:0] dropped,
                                                 input logic [CNT_W-1:0]  count);
        return {TAG_EOF, dropped, count};
    endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// First-word-fall-through FIFO with occupancy output.
// Latency: a write into an empty FIFO shows on rd_valid/rd_data the next cycle.
// Backpressure: head word held while rd_en is low; write+read at full is allowed.
module sync_fifo_fwft #(
    parameter int WIDTH = 24,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic                     rd_valid,
    output logic [WIDTH-1:0]         rd_data,
    output logic [$clog2(DEPTH):0]   occupancy
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      occ;
    logic             do_wr;
    logic             do_rd;

    assign do_rd     = rd_en && (occ != '0);
    assign do_wr     = wr_en && ((occ != FULL_CNT) || do_rd);
    assign rd_valid  = (occ != '0);
    // Zero when empty so the output bus reads 0 out of reset.
    assign rd_data   = rd_valid ? mem[rd_ptr] : '0;
    assign occupancy = occ;

    // Storage array, written only when accepted.
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers and occupancy; power-of-two depth lets pointers wrap naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
            case ({do_wr, do_rd})
                2'b10:   occ <= occ + 1'b1;
                2'b01:   occ <= occ - 1'b1;
                default: occ <= occ;
            endcase
        end
    end

endmodule

// File: rtl/corner_list_packer.sv
// Packs detector corner flags into {tag,y,x} records plus a per-frame EOF summary.
// Latency: 1 cycle from an accepted pixel to out_valid on an empty FIFO.
// Backpressure: input is never stalled; corners drop when only the EOF slot is left.
module corner_list_packer
    import corner_pkg::*;
#(
    parameter int IMAGE_WIDTH  = 320,
    parameter int IMAGE_HEIGHT = 464,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [7:0]  in_pixel,
    input  logic        in_corner,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [23:0] out_data,
    output logic        out_last,
    output logic        err_eof_lost
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0]        CORNER_MAX = (AW+1)'(FIFO_DEPTH - 2);
    localparam logic [AW:0]        FULL_CNT   = (AW+1)'(FIFO_DEPTH);
    localparam logic [COORD_W-1:0] X_LAST     = COORD_W'(IMAGE_WIDTH - 1);
    localparam logic [COORD_W-1:0] Y_LAST     = COORD_W'(IMAGE_HEIGHT - 1);

    state_t             state;
    logic [COORD_W-1:0] x_q;
    logic [COORD_W-1:0] y_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [DROP_W-1:0]  drop_q;
    logic [CNT_W-1:0]   pend_cnt;
    logic [DROP_W-1:0]  pend_drop;
    logic [AW:0]        occ;

    logic               frame_end;
    logic               corner_in;
    logic               corner_wr;
    logic               corner_drop;
    logic               eof_wr;
    logic [CNT_W-1:0]   cnt_nxt;
    logic [DROP_W-1:0]  drop_nxt;
    logic [REC_W-1:0]   wr_data;
    logic               pixel_unused;

    // The pixel value travels with the stream but carries nothing the packer needs.
    assign pixel_unused = ^in_pixel;

    // Admission: corners only in RUN and only while a slot beyond the EOF reserve exists.
    always_comb begin
        frame_end   = in_valid && (x_q == X_LAST) && (y_q == Y_LAST);
        corner_in   = in_valid && in_corner;
        corner_wr   = corner_in && (state == ST_RUN) && (occ <= CORNER_MAX);
        corner_drop = corner_in && !corner_wr;
        eof_wr      = (state == ST_EOF_PEND) && (occ < FULL_CNT);
        cnt_nxt     = (corner_wr && (cnt_q != '1)) ? cnt_q + 1'b1 : cnt_q;
        drop_nxt    = (corner_drop && (drop_q != '1)) ? drop_q + 1'b1 : drop_q;
        wr_data     = eof_wr ? eof_rec(pend_drop, pend_cnt) : corner_rec(y_q, x_q);
    end

    // Raster position, advancing once per valid pixel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q <= '0;
            y_q <= '0;
        end else if (in_valid) begin
            if (x_q == X_LAST) begin
                x_q <= '0;
                y_q <= (y_q == Y_LAST) ? '0 : y_q + 1'b1;
            end else begin
                x_q <= x_q + 1'b1;
            end
        end
    end

    // Frame FSM: at frame end the live counters move into the pending EOF snapshot and
    // restart, so anything arriving while EOF waits is charged to the new frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_RUN;
            cnt_q        <= '0;
            drop_q       <= '0;
            pend_cnt     <= '0;
            pend_drop    <= '0;
            err_eof_lost <= 1'b0;
        end else if (frame_end) begin
            pend_cnt  <= cnt_nxt;
            pend_drop <= drop_nxt;
            cnt_q     <= '0;
            drop_q    <= '0;
            state     <= ST_EOF_PEND;
            if ((state == ST_EOF_PEND) && !eof_wr) begin
                err_eof_lost <= 1'b1;
            end
        end else begin
            cnt_q  <= cnt_nxt;
            drop_q <= drop_nxt;
            if (eof_wr) begin
                state <= ST_RUN;
            end
        end
    end

    sync_fifo_fwft #(
        .WIDTH (REC_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en     (corner_wr || eof_wr),
        .wr_data   (wr_data),
        .rd_en     (out_ready),
        .rd_valid  (out_valid),
        .rd_data   (out_data),
        .occupancy (occ)
    );

    assign out_last = out_valid && (out_data[23:20] == TAG_EOF);

endmodule

// File: tb/tb_corner_list_packer.sv
// Directed bench for corner_list_packer on an 8x4 frame with a 4-entry record FIFO.
// Latency: records observed at the negedge before the accepting posedge.
// Backpressure: out_ready held, released or toggled per step.
module tb_corner_list_packer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [7:0]  in_pixel;
    logic        in_corner;
    logic        out_valid;
    logic        out_ready;
    logic [23:0] out_data;
    logic        out_last;
    logic        err_eof_lost;

    int vectors     = 0;
    int miscompares = 0;
    logic          tog = 1'b0;
    logic [24:0]   got[$];
    logic          prev_stall = 1'b0;
    logic [23:0]   prev_dat   = '0;

    always #5 clk = ~clk;

    corner_list_packer #(
        .IMAGE_WIDTH  (8),
        .IMAGE_HEIGHT (4),
        .FIFO_DEPTH   (4)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_pixel     (in_pixel),
        .in_corner    (in_corner),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_last     (out_last),
        .err_eof_lost (err_eof_lost)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [24:0] pop();
        if (got.size() == 0) return 'x;
        return got.pop_front();
    endfunction

    // Monitor: log accepted records and check the bus held still across each stall.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall <= 1'b0;
        end else begin
            if (prev_stall) begin
                chk("stall_valid", {31'd0, out_valid}, 32'd1);
                chk("stall_data", {8'd0, out_data}, {8'd0, prev_dat});
            end
            if (out_valid && out_ready) got.push_back({out_last, out_data});
            prev_stall <= out_valid && !out_ready;
            prev_dat   <= out_data;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        if (tog) out_ready = !out_ready;
    endtask

    task automatic pix(input logic c);
        in_valid  = 1'b1;
        in_corner = c;
        in_pixel  = in_pixel + 8'd1;
        step();
        in_valid  = 1'b0;
        in_corner = 1'b0;
    endtask

    task automatic frame(input logic [31:0] mask);
        for (int i = 0; i < 32; i++) pix(mask[i]);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_corner = 1'b0;
        in_pixel  = 8'd0;
        out_ready = 1'b0;
        #1;
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_last",  {31'd0, out_last}, 32'd0);
        chk("rst_data",  {8'd0, out_data}, 32'd0);
        chk("rst_err",   {31'd0, err_eof_lost}, 32'd0);
        idle(2);
        rst_n = 1'b1;
        idle(1);

        // Small frame, corners at (2,1) and (5,2), consumer always ready.
        out_ready = 1'b1;
        for (int i = 0; i < 32; i++) begin
            pix(i == 10 || i == 21);
            if (i == 9) chk("t2_pre_valid", {31'd0, out_valid}, 32'd0);
            if (i == 10) begin
                chk("t2_lat_valid", {31'd0, out_valid}, 32'd1);
                chk("t2_lat_data", {8'd0, out_data}, 32'h100402);
            end
        end
        idle(4);
        chk("t2_n",  got.size(), 32'd3);
        chk("t2_r0", {7'd0, pop()}, 32'h0100402);
        chk("t2_r1", {7'd0, pop()}, 32'h0100805);
        chk("t2_r2", {7'd0, pop()}, 32'h1F00002);

        // Stalled consumer: five corners, only three fit beside the EOF reserve.
        out_ready = 1'b0;
        frame(32'h0000001F);
        idle(3);
        chk("t3_valid", {31'd0, out_valid}, 32'd1);
        chk("t3_head", {8'd0, out_data}, 32'h100000);
        chk("t3_err", {31'd0, err_eof_lost}, 32'd0);
        out_ready = 1'b1;
        idle(6);
        chk("t3_n",  got.size(), 32'd4);
        chk("t3_r0", {7'd0, pop()}, 32'h0100000);
        chk("t3_r1", {7'd0, pop()}, 32'h0100001);
        chk("t3_r2", {7'd0, pop()}, 32'h0100002);
        chk("t3_r3", {7'd0, pop()}, 32'h1F02003);

        // Corner on the last pixel, then a corner at (0,0) in the EOF cycle.
        frame(32'h80000000);
        chk("t4_corner", {8'd0, out_data}, 32'h100C07);
        pix(1'b1);
        chk("t4_eof", {8'd0, out_data}, 32'hF00001);
        chk("t4_last", {31'd0, out_last}, 32'd1);
        for (int i = 1; i < 32; i++) pix(1'b0);
        idle(4);
        chk("t4_n",  got.size(), 32'd3);
        chk("t4_r0", {7'd0, pop()}, 32'h0100C07);
        chk("t4_r1", {7'd0, pop()}, 32'h1F00001);
        chk("t4_r2", {7'd0, pop()}, 32'h1F01000);

        // EOF collision: consumer stalled across three frames, middle EOF is lost.
        out_ready = 1'b0;
        frame(32'h00000007);
        frame(32'h00000001);
        chk("t5_err_before", {31'd0, err_eof_lost}, 32'd0);
        frame(32'h00000003);
        chk("t5_err_after", {31'd0, err_eof_lost}, 32'd1);
        out_ready = 1'b1;
        idle(8);
        chk("t5_n",  got.size(), 32'd5);
        chk("t5_r0", {7'd0, pop()}, 32'h0100000);
        chk("t5_r1", {7'd0, pop()}, 32'h0100001);
        chk("t5_r2", {7'd0, pop()}, 32'h0100002);
        chk("t5_r3", {7'd0, pop()}, 32'h1F00003);
        chk("t5_r4", {7'd0, pop()}, 32'h1F02000);

        // Reset at pixel (3,2) with two corners queued.
        out_ready = 1'b0;
        pix(1'b1);
        pix(1'b1);
        for (int i = 2; i < 19; i++) pix(1'b0);
        chk("t6_pre_valid", {31'd0, out_valid}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("t6_valid", {31'd0, out_valid}, 32'd0);
        chk("t6_data",  {8'd0, out_data}, 32'd0);
        chk("t6_last",  {31'd0, out_last}, 32'd0);
        chk("t6_err",   {31'd0, err_eof_lost}, 32'd0);
        idle(2);
        rst_n = 1'b1;
        got.delete();
        out_ready = 1'b1;
        frame(32'h00000020);
        idle(4);
        chk("t6_n",  got.size(), 32'd2);
        chk("t6_r0", {7'd0, pop()}, 32'h0100005);
        chk("t6_r1", {7'd0, pop()}, 32'h1F00001);

        // Consumer toggling every cycle.
        out_ready = 1'b0;
        tog = 1'b1;
        frame(32'h40100154);
        idle(10);
        tog = 1'b0;
        out_ready = 1'b1;
        idle(2);
        chk("t7_n",  got.size(), 32'd7);
        chk("t7_r0", {7'd0, pop()}, 32'h0100002);
        chk("t7_r1", {7'd0, pop()}, 32'h0100004);
        chk("t7_r2", {7'd0, pop()}, 32'h0100006);
        chk("t7_r3", {7'd0, pop()}, 32'h0100400);
        chk("t7_r4", {7'd0, pop()}, 32'h0100804);
        chk("t7_r5", {7'd0, pop()}, 32'h0100C06);
        chk("t7_r6", {7'd0, pop()}, 32'h1F00006);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
